// File: rtl/vga_timing_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_controller_pkg
// Description : Shared definitions for the VGA timing controller: the phase
//               encoding for each axis, the 640x480 default timing, and the
//               field positions inside the packed {s_blank, s_sync, r_sync,
//               total} configuration words.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_controller_pkg;

    // Width of one counter / one configuration field.
    localparam int CFG_W = 10;

    // Phase of one axis within its line (horizontal) or frame (vertical).
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // 640x480 @ 60 Hz default timing.
    localparam int DEF_H_S_BLANK = 640;
    localparam int DEF_H_S_SYNC  = 656;
    localparam int DEF_H_R_SYNC  = 752;
    localparam int DEF_H_TOTAL   = 800;
    localparam int DEF_V_S_BLANK = 480;
    localparam int DEF_V_S_SYNC  = 490;
    localparam int DEF_V_R_SYNC  = 492;
    localparam int DEF_V_TOTAL   = 525;

    // Field index inside a configuration word; bit offset = index * CFG_W.
    // Layout, MSB first: {s_blank, s_sync, r_sync, total}.
    localparam int FLD_TOTAL   = 0;
    localparam int FLD_R_SYNC  = 1;
    localparam int FLD_S_SYNC  = 2;
    localparam int FLD_S_BLANK = 3;

endpackage : vga_timing_controller_pkg
`default_nettype wire

// File: rtl/vga_axis_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_sequencer
// Description : One timing axis: a wrapping counter plus its four-phase
//               state (ACTIVE, FRONT, SYNC, BACK). The phase is derived from
//               the next count and registered together with it, so blank and
//               sync line up with the count they describe.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               advance_i       - step the counter this cycle
//               load_zero_i     - force count to 0 / phase to ACTIVE
//               s_blank_i .. total_i - live timing for this axis
//               count_o         - current count
//               blank_o, sync_o - phase flags for count_o
//               wrap_o          - count_o is the last count of the period
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_sequencer
    import vga_timing_controller_pkg::*;
#(
    parameter int C = CFG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance_i,
    input  logic         load_zero_i,
    input  logic [C-1:0] s_blank_i,
    input  logic [C-1:0] s_sync_i,
    input  logic [C-1:0] r_sync_i,
    input  logic [C-1:0] total_i,
    output logic [C-1:0] count_o,
    output logic         blank_o,
    output logic         sync_o,
    output logic         wrap_o
);

    logic [C-1:0] count_q, count_d;
    phase_e       state_q, state_d;

    // total >= 2 is guaranteed by the config check, so total-1 never wraps.
    // ">=" keeps the counter bounded even if a count were ever out of range.
    assign wrap_o = (count_q >= (total_i - 1'b1));

    always_comb begin
        count_d = count_q;
        state_d = PH_ACTIVE;

        if (load_zero_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = wrap_o ? '0 : (count_q + 1'b1);
        end

        // Checking from the latest phase back means an empty phase
        // (s_blank==s_sync, or r_sync==total) is simply never selected.
        if (count_d >= r_sync_i) begin
            state_d = PH_BACK;
        end else if (count_d >= s_sync_i) begin
            state_d = PH_SYNC;
        end else if (count_d >= s_blank_i) begin
            state_d = PH_FRONT;
        end else begin
            state_d = PH_ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            state_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign count_o = count_q;
    assign blank_o = (state_q != PH_ACTIVE);
    assign sync_o  = (state_q == PH_SYNC);

endmodule : vga_axis_sequencer
`default_nettype wire

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_controller
// Description : Horizontal/vertical pixel counters with blank/sync/active
//               strobes. A new timing set is offered on cfg_valid/cfg_ready,
//               checked for legality, held as pending and applied only at a
//               frame boundary so a frame is never torn.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               en                 - pixel enable; low freezes all timing
//               cfg_valid/ready    - config handshake
//               cfg_h, cfg_v       - {s_blank, s_sync, r_sync, total}
//               cfg_err            - pulse: offered config was illegal
//               hcount, vcount     - current pixel / line
//               hblank..vsync      - phase flags
//               active             - visible pixel
//               line_start         - hcount == 0
//               frame_start        - hcount == 0 and vcount == 0
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_controller
    import vga_timing_controller_pkg::*;
#(
    parameter int C         = CFG_W,
    parameter int H_S_BLANK = DEF_H_S_BLANK,
    parameter int H_S_SYNC  = DEF_H_S_SYNC,
    parameter int H_R_SYNC  = DEF_H_R_SYNC,
    parameter int H_TOTAL   = DEF_H_TOTAL,
    parameter int V_S_BLANK = DEF_V_S_BLANK,
    parameter int V_S_SYNC  = DEF_V_S_SYNC,
    parameter int V_R_SYNC  = DEF_V_R_SYNC,
    parameter int V_TOTAL   = DEF_V_TOTAL
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [4*C-1:0] cfg_h,
    input  logic [4*C-1:0] cfg_v,
    output logic           cfg_err,
    output logic [C-1:0]   hcount,
    output logic [C-1:0]   vcount,
    output logic           hblank,
    output logic           vblank,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic           line_start,
    output logic           frame_start
);

    localparam logic [4*C-1:0] DEF_H = {C'(H_S_BLANK), C'(H_S_SYNC),
                                        C'(H_R_SYNC),  C'(H_TOTAL)};
    localparam logic [4*C-1:0] DEF_V = {C'(V_S_BLANK), C'(V_S_SYNC),
                                        C'(V_R_SYNC),  C'(V_TOTAL)};

    // 0 < s_blank <= s_sync < r_sync <= total, total >= 2
    function automatic logic cfg_legal(input logic [4*C-1:0] f);
        logic [C-1:0] sb, ss, rs, tot;
        sb  = f[FLD_S_BLANK*C +: C];
        ss  = f[FLD_S_SYNC*C  +: C];
        rs  = f[FLD_R_SYNC*C  +: C];
        tot = f[FLD_TOTAL*C   +: C];
        return (sb != '0) && (sb <= ss) && (ss < rs) && (rs <= tot) &&
               (tot >= C'(2));
    endfunction

    logic [4*C-1:0] live_h_q, live_v_q;
    logic [4*C-1:0] pend_h_q, pend_v_q;
    logic           pend_valid_q;

    logic h_wrap, v_wrap;
    logic offer_legal, accept, frame_end, apply;

    assign offer_legal = cfg_legal(cfg_h) && cfg_legal(cfg_v);
    assign cfg_ready   = ~pend_valid_q;
    assign accept      = cfg_valid & cfg_ready & offer_legal;
    assign cfg_err     = cfg_valid & cfg_ready & ~offer_legal;

    // Pending was necessarily captured on an earlier edge, so an accept in
    // the frame-end cycle itself waits for the following frame end.
    assign frame_end = en & h_wrap & v_wrap;
    assign apply     = frame_end & pend_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_h_q     <= DEF_H;
            live_v_q     <= DEF_V;
            pend_h_q     <= '0;
            pend_v_q     <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            // accept needs cfg_ready, apply needs a pending set: exclusive.
            if (accept) begin
                pend_h_q     <= cfg_h;
                pend_v_q     <= cfg_v;
                pend_valid_q <= 1'b1;
            end else if (apply) begin
                live_h_q     <= pend_h_q;
                live_v_q     <= pend_v_q;
                pend_valid_q <= 1'b0;
            end
        end
    end

    vga_axis_sequencer #(.C(C)) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .advance_i   (en),
        .load_zero_i (apply),
        .s_blank_i   (live_h_q[FLD_S_BLANK*C +: C]),
        .s_sync_i    (live_h_q[FLD_S_SYNC*C  +: C]),
        .r_sync_i    (live_h_q[FLD_R_SYNC*C  +: C]),
        .total_i     (live_h_q[FLD_TOTAL*C   +: C]),
        .count_o     (hcount),
        .blank_o     (hblank),
        .sync_o      (hsync),
        .wrap_o      (h_wrap)
    );

    vga_axis_sequencer #(.C(C)) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .advance_i   (en & h_wrap),
        .load_zero_i (apply),
        .s_blank_i   (live_v_q[FLD_S_BLANK*C +: C]),
        .s_sync_i    (live_v_q[FLD_S_SYNC*C  +: C]),
        .r_sync_i    (live_v_q[FLD_R_SYNC*C  +: C]),
        .total_i     (live_v_q[FLD_TOTAL*C   +: C]),
        .count_o     (vcount),
        .blank_o     (vblank),
        .sync_o      (vsync),
        .wrap_o      (v_wrap)
    );

    assign active      = ~hblank & ~vblank;
    assign line_start  = (hcount == '0);
    assign frame_start = line_start & (vcount == '0);

endmodule : vga_timing_controller
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_controller
// Description : Self-checking bench. A small-timing instance is compared
//               every cycle against an arithmetic reference model; a second
//               instance with the 640x480 defaults checks the default line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_controller;

    localparam int C = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Small-timing instance
    logic           en = 1'b0, cfg_valid = 1'b0;
    logic [4*C-1:0] cfg_h = '0, cfg_v = '0;
    logic           cfg_ready, cfg_err, hblank, vblank, hsync, vsync;
    logic           active, line_start, frame_start;
    logic [C-1:0]   hcount, vcount;

    // Default-timing instance
    logic           en_d = 1'b0, cfg_valid_d = 1'b0;
    logic [4*C-1:0] cfg_h_d = '0, cfg_v_d = '0;
    logic           cfg_ready_d, cfg_err_d, hblank_d, vblank_d, hsync_d, vsync_d;
    logic           active_d, line_start_d, frame_start_d;
    logic [C-1:0]   hcount_d, vcount_d;

    vga_timing_controller #(
        .H_S_BLANK(12), .H_S_SYNC(14), .H_R_SYNC(17), .H_TOTAL(20),
        .V_S_BLANK(5),  .V_S_SYNC(6),  .V_R_SYNC(8),  .V_TOTAL(10)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_err(cfg_err),
        .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .vsync(vsync), .active(active),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_controller dut_def (
        .clk(clk), .rst(rst), .en(en_d), .cfg_valid(cfg_valid_d),
        .cfg_ready(cfg_ready_d), .cfg_h(cfg_h_d), .cfg_v(cfg_v_d),
        .cfg_err(cfg_err_d), .hcount(hcount_d), .vcount(vcount_d),
        .hblank(hblank_d), .vblank(vblank_d), .hsync(hsync_d),
        .vsync(vsync_d), .active(active_d), .line_start(line_start_d),
        .frame_start(frame_start_d)
    );

    logic [28:0] obs;
    assign obs = {cfg_ready, cfg_err, hcount, vcount, hblank, vblank,
                  hsync, vsync, active, line_start, frame_start};

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Timing sets held as [s_blank, s_sync, r_sync, total].
    int hc, vc;
    int lh[4], lv[4], ph[4], pv[4];
    bit pend;

    function automatic logic [4*C-1:0] pack(int a, int b, int c, int d);
        return {C'(a), C'(b), C'(c), C'(d)};
    endfunction

    function automatic bit bus_legal(logic [4*C-1:0] b);
        int sb, ss, rs, t;
        sb = int'(b[39:30]); ss = int'(b[29:20]);
        rs = int'(b[19:10]); t  = int'(b[9:0]);
        return (sb > 0) && (sb <= ss) && (ss < rs) && (rs <= t) && (t >= 2);
    endfunction

    function automatic void model_reset();
        hc = 0; vc = 0; pend = 1'b0;
        lh = '{12, 14, 17, 20};
        lv = '{5, 6, 8, 10};
    endfunction

    function automatic logic [28:0] model_expect();
        bit hb, vb, hs, vs, ok;
        hb = (hc >= lh[0]);
        vb = (vc >= lv[0]);
        hs = (hc >= lh[1]) && (hc < lh[2]);
        vs = (vc >= lv[1]) && (vc < lv[2]);
        ok = bus_legal(cfg_h) && bus_legal(cfg_v);
        return {!pend, cfg_valid && !pend && !ok, C'(hc), C'(vc),
                hb, vb, hs, vs, !hb && !vb, hc == 0, (hc == 0) && (vc == 0)};
    endfunction

    // One rising edge of behaviour, using the inputs present at the edge.
    function automatic void model_clock();
        bit acc, fe;
        acc = cfg_valid && !pend && bus_legal(cfg_h) && bus_legal(cfg_v);
        if (en) begin
            fe = (hc == lh[3] - 1) && (vc == lv[3] - 1);
            if (hc == lh[3] - 1) begin
                hc = 0;
                vc = (vc == lv[3] - 1) ? 0 : vc + 1;
            end else begin
                hc = hc + 1;
            end
            if (fe && pend) begin
                lh = ph; lv = pv; pend = 1'b0;
                hc = 0; vc = 0;
            end
        end
        if (acc) begin
            pend = 1'b1;
            ph = '{int'(cfg_h[39:30]), int'(cfg_h[29:20]), int'(cfg_h[19:10]), int'(cfg_h[9:0])};
            pv = '{int'(cfg_v[39:30]), int'(cfg_v[29:20]), int'(cfg_v[19:10]), int'(cfg_v[9:0])};
        end
    endfunction

    function automatic logic [4*C-1:0] gen_legal(int maxt);
        int t, sb, ss, rs;
        t  = $urandom_range(maxt, 2);
        sb = $urandom_range(t - 1, 1);
        ss = $urandom_range(t - 1, sb);
        rs = $urandom_range(t, ss + 1);
        return pack(sb, ss, rs, t);
    endfunction

    // Stimulus: called just after a falling edge.
    task automatic drive(input bit e, input bit v, input logic [4*C-1:0] h,
                         input logic [4*C-1:0] vv);
        en = e; cfg_valid = v; cfg_h = h; cfg_v = vv;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [28:0] exp_def;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        model_reset();
        checks++;
        if (obs !== model_expect()) begin
            errors++; $display("FAIL reset_small got=%h exp=%h", obs, model_expect());
        end
        exp_def = {1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        checks++;
        if ({cfg_ready_d, cfg_err_d, hcount_d, vcount_d, hblank_d, vblank_d, hsync_d,
             vsync_d, active_d, line_start_d, frame_start_d} !== exp_def) begin
            errors++; $display("FAIL reset_default got=%h exp=%h",
                {cfg_ready_d, cfg_err_d, hcount_d, vcount_d, hblank_d, vblank_d, hsync_d,
                 vsync_d, active_d, line_start_d, frame_start_d}, exp_def);
        end
        rst = 1'b0;
    endtask

    task automatic test_defaults();
        logic [25:0] got, exp;
        int h;
        drive(0, 0, '0, '0);
        en_d = 1'b1;
        for (int k = 0; k < 1700; k++) begin
            h = k % 800;
            exp = {C'(h), C'(k / 800), h >= 640, (h >= 656) && (h < 752), 1'b0, 1'b0,
                   (h < 640), h == 0};
            got = {hcount_d, vcount_d, hblank_d, hsync_d, vblank_d, vsync_d,
                   active_d, line_start_d};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL default_line k=%0d got=%h exp=%h", k, got, exp);
            end
            advance();
        end
        en_d = 1'b0;
    endtask

    task automatic test_load();
        for (int i = 0; i < 400; i++) begin
            drive(1, i == 37, pack(6, 7, 9, 10), pack(3, 4, 5, 6));
            checks++;
            if (obs !== model_expect()) begin
                errors++; $display("FAIL load i=%0d got=%h exp=%h", i, obs, model_expect());
            end
            if (i == 38) begin
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++; $display("FAIL load_ready_drop got=%b exp=0", cfg_ready);
                end
            end
            advance();
        end
    endtask

    task automatic test_zero_porch();
        int porch = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1, i == 5, pack(6, 6, 10, 10), pack(3, 4, 5, 6));
            checks++;
            if (obs !== model_expect()) begin
                errors++; $display("FAIL zero_porch i=%0d got=%h exp=%h", i, obs, model_expect());
            end
            if (i >= 200 && hblank && !hsync) porch++;
            advance();
        end
        checks++;
        if (porch != 0) begin
            errors++; $display("FAIL zero_porch_front_back got=%0d exp=0", porch);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 80; i++) begin
            drive(1, i == 3, pack(7, 6, 9, 10), pack(3, 4, 5, 6));
            checks++;
            if (obs !== model_expect()) begin
                errors++; $display("FAIL illegal i=%0d got=%h exp=%h", i, obs, model_expect());
            end
            if (i == 3 || i == 4) begin
                checks++;
                if ({cfg_err, cfg_ready} !== {i == 3, 1'b1}) begin
                    errors++; $display("FAIL illegal_err i=%0d got=%b%b exp=%b1",
                                       i, cfg_err, cfg_ready, i == 3);
                end
            end
            advance();
        end
    endtask

    task automatic test_en_hold();
        int n = 0;
        while (hc != 8 && n < 200) begin
            drive(1, 0, '0, '0);
            advance();
            n++;
        end
        checks++;
        if (hc != 8) begin
            errors++; $display("FAIL en_hold_reach got=%0d exp=8", hc);
        end
        for (int j = 0; j < 5; j++) begin
            drive(0, j == 1, pack(4, 5, 6, 8), pack(2, 3, 4, 5));
            checks++;
            if (obs !== model_expect() || hcount !== 10'd8) begin
                errors++; $display("FAIL en_hold j=%0d got=%h exp=%h", j, obs, model_expect());
            end
            advance();
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL en_hold_accept got=%b exp=0", cfg_ready);
        end
        for (int j = 0; j < 150; j++) begin
            drive(1, 0, '0, '0);
            checks++;
            if (obs !== model_expect()) begin
                errors++; $display("FAIL en_resume j=%0d got=%h exp=%h", j, obs, model_expect());
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [4*C-1:0] h, v;
        bit e, val;
        for (int i = 0; i < 3000; i++) begin
            e   = ($urandom_range(4, 0) != 0);
            val = ($urandom_range(19, 0) == 0);
            if ($urandom_range(9, 0) < 7) begin
                h = gen_legal(16); v = gen_legal(8);
            end else begin
                h = pack($urandom_range(15, 0), $urandom_range(15, 0),
                         $urandom_range(15, 0), $urandom_range(15, 0));
                v = gen_legal(8);
            end
            drive(e, val, h, v);
            checks++;
            if (obs !== model_expect()) begin
                errors++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, model_expect());
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!pend && n < 200) begin
            drive(1, 1, pack(3, 4, 5, 7), pack(2, 3, 4, 6));
            advance();
            n++;
        end
        drive(1, 0, '0, '0);
        advance();
        checks++;
        if (!pend || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL reset_mid_pending got=%b exp=0", cfg_ready);
        end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs !== model_expect()) begin
            errors++; $display("FAIL reset_mid got=%h exp=%h", obs, model_expect());
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 250; i++) begin
            drive(1, 0, '0, '0);
            checks++;
            if (obs !== model_expect()) begin
                errors++; $display("FAIL after_reset i=%0d got=%h exp=%h", i, obs, model_expect());
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_load();
        test_zero_porch();
        test_illegal();
        test_en_hold();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vga_timing_controller
`default_nettype wire
